// File: rtl/iic_init_sequencer.sv
// Power-up register loader: walks a command ROM and issues one I2C register write per entry.
// Latency: WRITE entry = 2 (fetch/decode) + 1 (issue) + bus time + DONE_IDLE_CLKS clocks.
// Backpressure: none on the ROM; the iic master is paced by SCL activity and a start watchdog.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   init_start                  one-cycle request to run the table from entry 0
//   init_busy/init_done         run in progress / one-cycle completion pulse
//   init_fail, fail_index       sticky failure flag and index of the failing entry
//   tbl_addr, tbl_data          synchronous table ROM port (data valid 1 cycle after addr)
//   iic_start .. slave_address  request port of the iic master (write-only usage)
//   iic_error, iic_error_reset  sticky NACK flag from the master and its clear pulse
//   scl                         master SCL line, monitored to detect transaction end
module iic_init_sequencer #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h3C,
  parameter int         ADDR_W         = 6,
  parameter int         MAX_RETRY      = 3,
  parameter int         DONE_IDLE_CLKS = 256,
  parameter int         START_TIMEOUT  = 1024,
  parameter int         DELAY_UNIT     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              init_fail,
  output logic [ADDR_W-1:0] fail_index,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              iic_start,
  output logic              iic_read_now,
  output logic [15:0]       iic_send_cnt,
  output logic [15:0]       iic_read_cnt,
  output logic [15:0]       iic_cmd_pack,
  output logic [6:0]        slave_address,
  input  logic              iic_error,
  output logic              iic_error_reset,
  input  logic              scl
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_ISSUE     = 4'd3;
  localparam logic [3:0] S_WAIT_BUSY = 4'd4;
  localparam logic [3:0] S_WAIT_DONE = 4'd5;
  localparam logic [3:0] S_ERR_CLR   = 4'd6;
  localparam logic [3:0] S_DELAY     = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_FAIL      = 4'd9;

  // One shared counter serves the start watchdog, the SCL-high counter and
  // the delay countdown; 32 bits covers 16-bit counts times DELAY_UNIT.
  localparam int CNT_W = 32;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       pack_q, pack_d;
  logic              busy_q, busy_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fidx_q, fidx_d;

  logic             advance;
  logic             enter_fail;
  logic             start_seq;
  logic [CNT_W-1:0] dly_load;

  // Type bits 21:16 are reserved in every entry kind.
  logic unused_tbl_bits;
  assign unused_tbl_bits = ^tbl_data[21:16];

  assign dly_load = CNT_W'(tbl_data[15:0]) * CNT_W'(DELAY_UNIT);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    pack_d     = pack_q;
    busy_d     = busy_q;
    fail_d     = fail_q;
    fidx_d     = fidx_q;
    advance    = 1'b0;
    enter_fail = 1'b0;
    start_seq  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_start) start_seq = 1'b1;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (tbl_data[23:22])
          2'b00: begin
            // reg byte goes in [7:0] because the master sends it first
            pack_d  = {tbl_data[7:0], tbl_data[15:8]};
            state_d = S_ISSUE;
          end
          2'b01: begin
            if (tbl_data[15:0] == 16'd0) begin
              advance = 1'b1;
            end else begin
              cnt_d   = dly_load;
              state_d = S_DELAY;
            end
          end
          default: begin
            state_d = S_DONE;
            busy_d  = 1'b0;
          end
        endcase
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!scl) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          enter_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // Transaction is over once SCL has stayed high long enough that it
        // cannot be a clock high phase.
        if (!scl) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DONE_IDLE_CLKS - 1)) begin
          if (iic_error) begin
            state_d = S_ERR_CLR;
          end else begin
            retry_d = '0;
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERR_CLR: begin
        if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          enter_fail = 1'b1;
        end
      end
      S_DELAY: begin
        // Loaded with count*DELAY_UNIT and left at 1 so the stay in DELAY
        // is exactly that many clocks.
        if (cnt_q <= CNT_W'(1)) advance = 1'b1;
        else                    cnt_d = cnt_q - 1'b1;
      end
      S_DONE, S_FAIL: begin
        if (init_start) start_seq = 1'b1;
        else            state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Running off the end of the table counts as an END entry.
    if (advance) begin
      if (idx_q == IDX_LAST) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    if (enter_fail) begin
      state_d = S_FAIL;
      busy_d  = 1'b0;
      fail_d  = 1'b1;
      fidx_d  = idx_q;
    end

    if (start_seq) begin
      idx_d   = '0;
      retry_d = '0;
      fail_d  = 1'b0;
      busy_d  = 1'b1;
      state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      pack_q  <= '0;
      busy_q  <= 1'b0;
      fail_q  <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      busy_q  <= busy_d;
      fail_q  <= fail_d;
      fidx_q  <= fidx_d;
    end
  end

  assign init_busy       = busy_q;
  assign init_done       = (state_q == S_DONE);
  assign init_fail       = fail_q;
  assign fail_index      = fidx_q;
  assign tbl_addr        = idx_q;
  assign iic_start       = (state_q == S_ISSUE);
  assign iic_error_reset = (state_q == S_ERR_CLR);
  assign iic_cmd_pack    = pack_q;
  assign iic_read_now    = 1'b0;
  assign iic_send_cnt    = 16'd2;
  assign iic_read_cnt    = 16'd0;
  assign slave_address   = SLAVE_ADDR;

endmodule

// File: tb/tb_iic_init_sequencer.sv
// Bench for iic_init_sequencer: table ROM and a behavioural I2C master model
// surround the DUT; expectations come from walking the table at entry level.
module tb_iic_init_sequencer;
  localparam int AW   = 6;
  localparam int MAXR = 3;
  localparam int STO  = 1024;
  localparam int DU   = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_start = 1'b0;
  logic          init_busy, init_done, init_fail;
  logic [AW-1:0] fail_index, tbl_addr;
  logic [23:0]   tbl_data;
  logic          iic_start, iic_read_now, iic_error_reset;
  logic [15:0]   iic_send_cnt, iic_read_cnt, iic_cmd_pack;
  logic [6:0]    slave_address;
  logic          iic_error = 1'b0;
  logic          scl = 1'b1;

  iic_init_sequencer dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done), .init_fail(init_fail),
    .fail_index(fail_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .iic_start(iic_start), .iic_read_now(iic_read_now),
    .iic_send_cnt(iic_send_cnt), .iic_read_cnt(iic_read_cnt),
    .iic_cmd_pack(iic_cmd_pack), .slave_address(slave_address),
    .iic_error(iic_error), .iic_error_reset(iic_error_reset), .scl(scl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] rom [64];
  int          nack_cfg [64];
  int          nack_left [64];
  bit          stall = 1'b0;
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // Master model: after iic_start, clocks 9 bit times on SCL with a random
  // half period, then releases SCL and raises the sticky error on a NACK.
  int m_cnt = 0, m_tot = 0, m_h = 1, m_p;
  bit m_nack = 1'b0;
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; scl = 1'b1; iic_error = 1'b0;
      end else begin
        if (iic_error_reset) iic_error = 1'b0;
        if (m_cnt == 0) begin
          if (iic_start && !stall) begin
            m_h   = $urandom_range(1, 6);
            m_tot = 2 + 18 * m_h;
            m_cnt = m_tot;
            m_nack = nack_left[tbl_addr] > 0;
            if (m_nack) nack_left[tbl_addr] = nack_left[tbl_addr] - 1;
          end
        end else begin
          m_cnt = m_cnt - 1;
          m_p   = m_tot - m_cnt;
          if (m_cnt == 0) begin
            scl = 1'b1;
            if (m_nack) iic_error = 1'b1;
          end else if (m_p < 2) begin
            scl = 1'b1;
          end else begin
            scl = (((m_p - 2) / m_h) % 2) != 0;
          end
        end
      end
    end
  end

  // Observation log
  logic [15:0] st_pack[$];
  int          st_addr[$];
  int rst_cnt = 0, done_cnt = 0, done_cyc = 0, fail_cyc = 0, last_start_cyc = 0;
  bit fail_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (iic_start) begin
          st_pack.push_back(iic_cmd_pack);
          st_addr.push_back(int'(tbl_addr));
          last_start_cyc = cyc;
        end
        if (iic_error_reset) rst_cnt = rst_cnt + 1;
        if (init_done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
        if (init_fail && !fail_prev) fail_cyc = cyc;
        fail_prev = init_fail;
      end else begin
        fail_prev = 1'b0;
      end
    end
  end

  // Reference model: what the table run should produce, entry by entry.
  logic [15:0] exp_pack[$];
  int          exp_addr[$];
  int exp_resets, exp_fidx;
  bit exp_done, exp_fail;

  task automatic model();
    int i, n, a;
    bit stop;
    logic [23:0] w;
    exp_pack.delete(); exp_addr.delete();
    exp_resets = 0; exp_done = 0; exp_fail = 0; exp_fidx = 0;
    i = 0; stop = 0;
    while (!stop) begin
      w = rom[i];
      if (w[23]) begin
        exp_done = 1; stop = 1;
      end else begin
        if (!w[22]) begin
          n = nack_cfg[i];
          a = stall ? 1 : ((n > MAXR) ? MAXR + 1 : n + 1);
          repeat (a) begin
            exp_pack.push_back({w[7:0], w[15:8]});
            exp_addr.push_back(i);
          end
          if (stall) begin
            exp_fail = 1; exp_fidx = i; stop = 1;
          end else if (n > MAXR) begin
            exp_fail = 1; exp_fidx = i; stop = 1; exp_resets += a;
          end else begin
            exp_resets += n;
          end
        end
        if (!stop) begin
          if (i == 63) begin exp_done = 1; stop = 1; end
          else i++;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " busy"},      32'(init_busy), 32'd0);
    check({tag, " done"},      32'(init_done), 32'd0);
    check({tag, " fail"},      32'(init_fail), 32'd0);
    check({tag, " fidx"},      32'(fail_index), 32'd0);
    check({tag, " addr"},      32'(tbl_addr), 32'd0);
    check({tag, " start"},     32'(iic_start), 32'd0);
    check({tag, " errrst"},    32'(iic_error_reset), 32'd0);
    check({tag, " pack"},      32'(iic_cmd_pack), 32'd0);
    check({tag, " consts"},    {iic_read_now, iic_send_cnt, iic_read_cnt[7:0], slave_address},
                               {1'b0, 16'd2, 8'd0, 7'h3C});
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) begin
      rom[i] = 24'h800000;
      nack_cfg[i] = 0;
    end
  endtask

  int start_cyc = 0;
  task automatic run(input string tag, input int poke_at);
    int  n;
    bit  timed_out;
    model();
    for (int i = 0; i < 64; i++) nack_left[i] = nack_cfg[i];
    @(posedge clk); #1;
    st_pack.delete(); st_addr.delete(); rst_cnt = 0; done_cnt = 0;
    @(negedge clk); init_start = 1'b1; start_cyc = cyc + 1;
    @(negedge clk); init_start = 1'b0;
    n = 0; timed_out = 1;
    while (n < 40000) begin
      @(negedge clk); n++;
      init_start = (n == poke_at);
      if (!init_busy) begin timed_out = 0; break; end
    end
    init_start = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, " finished"}, 32'(timed_out), 32'd0);
    check({tag, " starts"}, 32'(st_pack.size()), 32'(exp_pack.size()));
    for (int k = 0; k < exp_pack.size() && k < st_pack.size(); k++) begin
      check($sformatf("%s pack%0d", tag, k), {st_pack[k], 16'(st_addr[k])},
            {exp_pack[k], 16'(exp_addr[k])});
    end
    check({tag, " done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, " fail"}, 32'(init_fail), 32'(exp_fail));
    if (exp_fail) check({tag, " fidx"}, 32'(fail_index), 32'(exp_fidx));
    check({tag, " errrst"}, 32'(rst_cnt), 32'(exp_resets));
  endtask

  initial begin
    int diff, found, r;
    clear_rom();
    for (int i = 0; i < 64; i++) nack_left[i] = 0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("after reset");

    // Two writes, all ACKed
    clear_rom();
    rom[0] = 24'h0010A5; rom[1] = 24'h00115A;
    run("two writes", 0);

    // Delay only: done lands count*DU+4 clocks after init_start
    clear_rom();
    rom[0] = 24'h400003;
    run("delay3", 0);
    diff = done_cyc - start_cyc;
    check("delay timing", 32'((diff >= 3 * DU + 3 && diff <= 3 * DU + 5) ? 3 * DU + 4 : diff),
          32'(3 * DU + 4));

    // Entry 2 NACKs forever
    clear_rom();
    rom[0] = 24'h000101; rom[1] = 24'h000202; rom[2] = 24'h000303; rom[3] = 24'h000404;
    nack_cfg[2] = 99;
    run("nack forever", 0);

    // Entry 0 NACKs once
    clear_rom();
    rom[0] = 24'h0020C3; rom[1] = 24'h400000; rom[2] = 24'h00213C;
    nack_cfg[0] = 1;
    run("nack once", 0);

    // Stalled master: watchdog fires
    clear_rom();
    rom[0] = 24'h003077;
    stall = 1'b1;
    run("stall", 0);
    stall = 1'b0;
    diff = fail_cyc - last_start_cyc;
    check("stall timing", 32'((diff >= STO && diff <= STO + 2) ? STO : diff), 32'(STO));

    // Index wrap without END
    clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 24'h400000;
    run("wrap", 0);

    // Reset in WAIT_DONE, then restart with a stray init_start while busy
    clear_rom();
    rom[0] = 24'h0010A5; rom[1] = 24'h00115A;
    for (int i = 0; i < 64; i++) nack_left[i] = 0;
    @(negedge clk); init_start = 1'b1;
    @(negedge clk); init_start = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (!scl) found = 1;
    end
    check("reach wait_done", 32'(found), 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("mid reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post reset busy", 32'(init_busy), 32'd0);
    run("restart", 50);

    // Random tables
    for (int t = 0; t < 6; t++) begin
      int nw;
      clear_rom();
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          rom[i] = {2'b01, 6'd0, 16'($urandom_range(0, 1))};
        end else begin
          rom[i] = {2'b00, 6'd0, 8'($urandom), 8'($urandom)};
          r = $urandom_range(0, 9);
          nack_cfg[i] = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 3) : 4;
        end
      end
      rom[nw] = {1'b1, 1'($urandom), 22'($urandom)};
      run($sformatf("rand%0d", t), $urandom_range(5, 40));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/iic_init_sequencer.md
Name: iic_init_sequencer

Overview:
- Controller that configures an I2C slave at power-up by walking a command table and driving the `iic` master's request port, one register write per transaction.
- Sits between a synchronous table ROM (1-cycle read latency) and the `iic` master.
- Detects transaction completion from the SCL line and retries failed writes.
- Reports busy, done and fail status to the system.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit I2C address driven to the master.
- ADDR_W, 6, table address width; table depth is 2^ADDR_W.
- MAX_RETRY, 3, retries per entry after the first attempt.
- DONE_IDLE_CLKS, 256, consecutive SCL-high clocks that mean the transaction is finished. Must exceed the SCL half period.
- START_TIMEOUT, 1024, clocks allowed from `iic_start` until SCL first goes low.
- DELAY_UNIT, 1024, clocks per delay-entry count.

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  single-cycle request to run the table from entry 0
- init_busy  out  1  high while the sequence runs
- init_done  out  1  single-cycle pulse when the end entry is reached
- init_fail  out  1  sticky failure flag; cleared by the next init_start
- fail_index  out  ADDR_W  table index of the failing entry
- tbl_addr  out  ADDR_W  table read address
- tbl_data  in  24  table word, valid 1 cycle after tbl_addr
- iic_start  out  1  single-cycle transaction request
- iic_read_now  out  1  tied 0 (write-only)
- iic_send_cnt  out  16  constant 2
- iic_read_cnt  out  16  constant 0
- iic_cmd_pack  out  16  {data, reg}; [7:0] (reg) is sent first
- slave_address  out  7  SLAVE_ADDR
- iic_error  in  1  sticky NACK flag from the master
- iic_error_reset  out  1  single-cycle clear pulse to the master
- scl  in  1  master SCL, used as a completion monitor

Behaviour:
- Reset values: all outputs 0 except slave_address = SLAVE_ADDR and iic_send_cnt = 2. Internal state is IDLE with index 0 and retry 0.
- Table word format (tbl_data[23:22] selects the type):
  - 00 WRITE: reg = [15:8], data = [7:0].
  - 01 DELAY: count = [15:0]; waits count*DELAY_UNIT clocks. A count of 0 means no wait.
  - 10 or 11: END.
- IDLE:
  - On init_start, set idx=0 and retry=0, clear init_fail, set init_busy=1, go to FETCH.
  - init_start is ignored outside IDLE, DONE and FAIL.
- FETCH: drive tbl_addr=idx for 1 cycle, then go to DECODE; tbl_data is sampled in DECODE.
- DECODE:
  - WRITE: latch iic_cmd_pack, go to ISSUE.
  - DELAY: load the counter, go to DELAY.
  - END: go to DONE.
- ISSUE: iic_start=1 for exactly 1 cycle; clear the watchdog; go to WAIT_BUSY.
- WAIT_BUSY:
  - On scl==0, go to WAIT_DONE.
  - If the watchdog reaches START_TIMEOUT first, go to FAIL.
- WAIT_DONE:
  - The high-counter increments while scl==1 and resets on scl==0.
  - On reaching DONE_IDLE_CLKS:
    - iic_error==0: idx+1, retry=0, go to FETCH.
    - iic_error==1: go to ERR_CLR.
- ERR_CLR:
  - iic_error_reset=1 for 1 cycle.
  - If retry<MAX_RETRY: retry+1, go to ISSUE (same entry, same pack).
  - Otherwise go to FAIL.
- DELAY: count down to 0, then idx+1 and go to FETCH.
- DONE: init_done=1 for 1 cycle, init_busy=0, go to IDLE.
- FAIL: init_fail=1 (sticky), fail_index=idx, init_busy=0, go to IDLE.
- Index wrap: if idx would wrap past 2^ADDR_W-1 without an END entry, treat it as END and go to DONE.
- Reset mid-operation aborts immediately. The master is reset by the same rst_n.
- iic_cmd_pack is held stable from ISSUE until the next DECODE.
- Latency: a WRITE entry costs 2 (FETCH/DECODE) + 1 (ISSUE) + bus time + DONE_IDLE_CLKS.

Test Plan:
- Table {W 0x10/0xA5, W 0x11/0x5A, END}, slave always ACKs -> two iic_start pulses with packs 0xA510 then 0x5A11; init_done pulses once; init_fail stays 0.
- Table {DELAY 3, END} -> no iic_start; init_done pulses 3*1024+4 cycles (±1) after init_start.
- Entry 2 NACKs on every attempt -> 4 iic_start pulses for entry 2 and 4 iic_error_reset pulses; init_fail=1, fail_index=2, no init_done.
- Entry 0 NACKs once, then ACKs -> 2 iic_start pulses for entry 0, sequence completes, init_done pulses.
- Held SCL high (master stalled) -> FAIL START_TIMEOUT cycles after iic_start; fail_index=0.
- rst_n asserted during WAIT_DONE, then init_start -> all outputs at reset values, sequence restarts at entry 0; init_start pulsed while busy has no effect.
